// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, frame defaults and clocking constants.
// Also used by uart_baud_rate_gen for its divider.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam int DBIT_DEF       = 8;
    localparam int OVERSAMPLE_DEF = 16;
    localparam int SB_TICK_DEF    = 16;
    localparam int CLK_HZ         = 50_000_000;
    localparam int BAUD           = 115200;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte request/completion handshake between producer and uart_tx.
`timescale 1ns/1ps
interface uart_tx_if
    import uart_pkg::*;
#(
    parameter int DBIT = DBIT_DEF
);
    logic            tx_start;
    logic [DBIT-1:0] din;
    logic            tx_busy;
    logic            tx_done_tick;

    modport master (
        output tx_start,
        output din,
        input  tx_busy,
        input  tx_done_tick
    );

    modport slave (
        input  tx_start,
        input  din,
        output tx_busy,
        output tx_done_tick
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter paced by an oversampling tick.
// Frame is a start bit, DBIT data bits LSB first, then the stop bit.
`timescale 1ns/1ps
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT       = DBIT_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int SB_TICK    = SB_TICK_DEF
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     tick,
    uart_tx_if.slave bus,
    output logic     tx
);
    localparam int S_W = cnt_w(max_int(OVERSAMPLE, SB_TICK));
    localparam int N_W = cnt_w(DBIT);
    localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST      = N_W'(DBIT - 1);

    state_e          state_q, state_d;
    logic [S_W-1:0]  s_q, s_d;
    logic [N_W-1:0]  n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.tx_start) begin
                    b_d     = bus.din;
                    s_d     = '0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == S_STOP_LAST) begin
                        s_d     = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is registered from the upcoming state so it tracks state_q.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign tx               = tx_q;
    assign bus.tx_busy      = (state_q != IDLE);
    assign bus.tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed tests for uart_tx with hand-derived frames.
`timescale 1ns/1ps
module tb_uart_tx;
    import uart_pkg::*;

    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE_DEF);

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic tick;
    logic tx;
    int   mode  = 0;
    int   div   = 0;
    int   total = 0;
    int   bad   = 0;

    logic cap_tx   [0:511];
    logic cap_done [0:511];
    logic cap_busy [0:511];
    int   ci = 0;

    uart_tx_if #(.DBIT(8)) bus ();

    uart_tx dut (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .bus   (bus),
        .tx    (tx)
    );

    always #10 clk = ~clk;

    always @(posedge clk) div <= (div == DIV - 1) ? 0 : div + 1;

    assign tick = (mode == 1) || (mode == 2 && div == 0);

    task automatic cap(input int n);
        for (int i = 0; i < n; i++) begin
            if (ci < 512) begin
                cap_tx[ci]   = tx;
                cap_done[ci] = bus.tx_done_tick;
                cap_busy[ci] = bus.tx_busy;
            end
            ci++;
            @(negedge clk);
        end
    endtask

    task automatic pulse(input logic [7:0] d);
        @(negedge clk);
        bus.din      = d;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        ci = 0;
    endtask

    task automatic test_reset;
        mode = 2;
        #5 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({tx, bus.tx_busy, bus.tx_done_tick} !== 3'b100) begin
                bad++;
                $display("FAIL reset_hold got=%b want=100",
                         {tx, bus.tx_busy, bus.tx_done_tick});
            end
        end
        reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            total++;
            if ({tx, bus.tx_busy, bus.tx_done_tick} !== 3'b100) begin
                bad++;
                $display("FAIL reset_idle got=%b want=100",
                         {tx, bus.tx_busy, bus.tx_done_tick});
            end
        end
    endtask

    task automatic test_single_frame;
        logic [9:0] fr;
        int errs, cnt, first;
        mode = 1;
        fr = {1'b1, 8'h55, 1'b0};
        pulse(8'h55);
        cap(176);
        for (int b = 0; b < 10; b++) begin
            errs = 0;
            for (int j = 0; j < 16; j++)
                if (cap_tx[b*16+j] !== fr[b]) errs++;
            total++;
            if (errs != 0) begin
                bad++;
                $display("FAIL single_bit%0d got=%0d_wrong_clks want=%b_x16",
                         b, errs, fr[b]);
            end
        end
        cnt = 0;
        first = -1;
        for (int k = 0; k < 176; k++)
            if (cap_done[k] === 1'b1) begin
                cnt++;
                if (first < 0) first = k;
            end
        total++;
        if (cnt != 1) begin
            bad++;
            $display("FAIL single_done_count got=%0d want=1", cnt);
        end
        total++;
        if (first != 160) begin
            bad++;
            $display("FAIL single_done_at got=%0d want=160", first);
        end
        total++;
        if (cap_busy[161] !== 1'b0) begin
            bad++;
            $display("FAIL single_busy_after got=%b want=0", cap_busy[161]);
        end
        total++;
        if (cap_busy[0] !== 1'b1) begin
            bad++;
            $display("FAIL single_busy_during got=%b want=1", cap_busy[0]);
        end
    endtask

    task automatic test_ignored_request;
        logic [7:0] exp;
        int cnt;
        mode = 1;
        exp = 8'hA3;
        pulse(8'hA3);
        cap(50);
        bus.din      = 8'hFF;
        bus.tx_start = 1'b1;
        cap(1);
        bus.tx_start = 1'b0;
        cap(129);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (cap_tx[24+16*i] !== exp[i]) begin
                bad++;
                $display("FAIL ignored_bit%0d got=%b want=%b",
                         i, cap_tx[24+16*i], exp[i]);
            end
        end
        cnt = 0;
        for (int k = 0; k < 180; k++)
            if (cap_done[k] === 1'b1) cnt++;
        total++;
        if (cnt != 1) begin
            bad++;
            $display("FAIL ignored_done_count got=%0d want=1", cnt);
        end
        total++;
        if (cap_tx[170] !== 1'b1 || cap_busy[170] !== 1'b0) begin
            bad++;
            $display("FAIL ignored_idle got=%b%b want=10",
                     cap_tx[170], cap_busy[170]);
        end
    endtask

    task automatic test_back_to_back;
        int cnt, errs;
        mode = 1;
        @(negedge clk);
        bus.din      = 8'h00;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.din = 8'hFF;
        ci = 0;
        cap(161);
        bus.tx_start = 1'b0;
        cap(179);
        errs = 0;
        for (int k = 0; k < 144; k++)
            if (cap_tx[k] !== 1'b0) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL b2b_frame0_low got=%0d_wrong want=0", errs);
        end
        total++;
        if (cap_done[160] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done0 got=%b want=1", cap_done[160]);
        end
        total++;
        if (cap_tx[160] !== 1'b1 || cap_tx[161] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_gap got=%b%b want=10", cap_tx[160], cap_tx[161]);
        end
        errs = 0;
        for (int k = 177; k < 321; k++)
            if (cap_tx[k] !== 1'b1) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL b2b_frame1_high got=%0d_wrong want=0", errs);
        end
        cnt = 0;
        for (int k = 0; k < 340; k++)
            if (cap_done[k] === 1'b1) cnt++;
        total++;
        if (cnt != 2 || cap_done[321] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done got=%0d_at321=%b want=2_at321=1",
                     cnt, cap_done[321]);
        end
    endtask

    task automatic test_async_reset;
        logic [9:0] fr;
        int errs;
        mode = 1;
        pulse(8'hF0);
        repeat (70) @(negedge clk);
        total++;
        if (tx !== 1'b0) begin
            bad++;
            $display("FAIL areset_pre_tx got=%b want=0", tx);
        end
        #3 reset = 1'b0;
        #1;
        total++;
        if ({tx, bus.tx_busy, bus.tx_done_tick} !== 3'b100) begin
            bad++;
            $display("FAIL areset_now got=%b want=100",
                     {tx, bus.tx_busy, bus.tx_done_tick});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({tx, bus.tx_busy, bus.tx_done_tick} !== 3'b100) begin
                bad++;
                $display("FAIL areset_hold got=%b want=100",
                         {tx, bus.tx_busy, bus.tx_done_tick});
            end
        end
        reset = 1'b1;
        fr = {1'b1, 8'h0F, 1'b0};
        pulse(8'h0F);
        cap(170);
        errs = 0;
        for (int b = 0; b < 10; b++)
            for (int j = 0; j < 16; j++)
                if (cap_tx[b*16+j] !== fr[b]) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL areset_refr got=%0d_wrong_clks want=0", errs);
        end
        total++;
        if (cap_done[160] !== 1'b1) begin
            bad++;
            $display("FAIL areset_refr_done got=%b want=1", cap_done[160]);
        end
    endtask

    task automatic test_real_baud;
        longint et [0:7];
        longint tdone, dt;
        int     bnd [0:5];
        int     ne, nb;
        logic   prev, seen;
        bnd = '{0, 1, 2, 7, 8, 9};
        mode = 2;
        ne = 0;
        seen = 1'b0;
        tdone = 0;
        prev = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 100 && div != 0; c++) @(negedge clk);
        bus.din      = 8'h41;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            if (tx !== prev) begin
                if (ne < 8) et[ne] = $time;
                ne++;
                prev = tx;
            end
            if (bus.tx_done_tick === 1'b1) begin
                seen = 1'b1;
                tdone = $time;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!seen || ne != 6) begin
            bad++;
            $display("FAIL baud_edges got=%0d_done=%b want=6_done=1", ne, seen);
        end
        if (seen && ne == 6) begin
            for (int i = 1; i < 6; i++) begin
                dt = et[i] - et[i-1];
                nb = bnd[i] - bnd[i-1];
                total++;
                if (dt * 100 < longint'(nb) * 8680 * 98 ||
                    dt * 100 > longint'(nb) * 8680 * 102) begin
                    bad++;
                    $display("FAIL baud_span%0d got=%0dns want=%0dns+-2pct",
                             i, dt, nb * 8680);
                end
            end
            dt = tdone - et[5];
            total++;
            if (dt * 100 < 8680 * 98 || dt * 100 > 8680 * 102) begin
                bad++;
                $display("FAIL baud_stop got=%0dns want=8680ns+-2pct", dt);
            end
        end
    endtask

    initial begin
        bus.tx_start = 1'b0;
        bus.din      = 8'h00;
        test_reset;
        test_single_frame;
        test_ignored_request;
        test_back_to_back;
        test_async_reset;
        test_real_baud;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter stage directly downstream of uart_baud_rate_gen.
- Consumes that block's `tick` (16x oversampling enable, one clk cycle wide) and converts a parallel byte into an 8N1 asynchronous frame on `tx` at 115200 baud.
- Sits between the binary_counter datapath (byte producer) and the board UART pin.

Parameters:
- DBIT, 8, number of data bits per frame, sent LSB first.
- OVERSAMPLE, 16, `tick` pulses per bit period for start and data bits.
- SB_TICK, 16, `tick` pulses spent in the stop bit (16 = 1 stop bit, 32 = 2).

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- tick  input  1  oversampling enable from uart_baud_rate_gen; one-cycle pulse.
- tx_start  input  1  request to send `din`; sampled every clk.
- din  input  DBIT  byte to transmit; captured on the accepted `tx_start`.
- tx  output  1  serial line; idle high.
- tx_busy  output  1  high from the cycle after acceptance until the cycle `tx_done_tick` fires.
- tx_done_tick  output  1  one-clk pulse at end of stop bit.

Behaviour:
- Reset (`reset` = 0, asynchronous):
  - state = IDLE, `tx` = 1, `tx_busy` = 0, `tx_done_tick` = 0.
  - Tick counter, bit counter and shift register cleared.
  - Takes effect immediately, including mid-frame; the frame is abandoned and `tx` returns high without waiting for a clock.
- All registers update on posedge clk. `tx` is registered, so there is no combinational path from inputs to `tx`.
- State machine (IDLE, START, DATA, STOP):
  - IDLE: `tx` = 1. If `tx_start` = 1: latch `din` into the shift register, clear tick counter `s`, go to START. `tick` is not required for acceptance.
  - START: `tx` = 0. On each `tick`, `s` increments. On the tick where `s` = OVERSAMPLE-1: `s` := 0, bit counter `n` := 0, go to DATA.
  - DATA: `tx` = shift register bit 0. On the tick where `s` = OVERSAMPLE-1:
    - `s` := 0 and the shift register shifts right by 1.
    - If `n` = DBIT-1, go to STOP; else `n` increments.
  - STOP: `tx` = 1. On the tick where `s` = SB_TICK-1: assert `tx_done_tick` for exactly one clk, go to IDLE.
- Latency:
  - `tx` falls on the first clk edge after `tx_start` is seen in IDLE.
  - Frame length is (1 + DBIT)·OVERSAMPLE + SB_TICK ticks: 160 ticks with defaults, about 86.8 µs at 115200 baud.
- `tx_start` while not in IDLE is ignored: no queueing, `din` is not re-latched, and the frame in progress is unaffected.
- `tx_start` held high continuously: a new frame starts on the first clk in IDLE after `tx_done_tick`, giving back-to-back frames with a one-clk idle-high gap.
- `din` changes after acceptance have no effect on the current frame.
- `tick` absent: all counters and `tx` hold; no timeout.
- `tick` is asserted every clk (bench speed-up): behaviour is identical, and each bit lasts OVERSAMPLE clks.
- Counter widths:
  - `s` is wide enough for max(OVERSAMPLE, SB_TICK)-1; with the default value of 16 it is 4 bits in both cases.
  - `n` is ceil(log2(DBIT)) bits.
- Counters never wrap outside the transitions above.
- `tx_busy` = (state != IDLE).

Decomposition:
- Shared package/header uart_pkg:
  - state encoding constants IDLE, START, DATA, STOP;
  - default DBIT, OVERSAMPLE, SB_TICK;
  - CLK_HZ = 50_000_000 and BAUD = 115200, shared with uart_baud_rate_gen.
- No sub-module. uart_baud_rate_gen is instantiated beside uart_tx at the uart top level, not inside it.

Test Plan:
- Reset behaviour: assert `reset` = 0 for 100 ns with clk at 20 ns period, `tick` free-running from uart_baud_rate_gen.
  - Required: `tx` = 1, `tx_busy` = 0, `tx_done_tick` = 0 throughout, and until the first `tx_start`.
- Single frame: `din` = 8'h55, one-cycle `tx_start`, `tick` tied high.
  - Required: `tx` = 0 for 16 clks.
  - Then 1,0,1,0,1,0,1,0 at 16 clks each.
  - Then 1 for 16 clks.
  - `tx_done_tick` high exactly once, 160 clks after `tx` first falls; `tx_busy` low the next cycle.
- Ignored request: `din` = 8'hA3, start the frame, then pulse `tx_start` with `din` = 8'hFF mid-DATA.
  - Required: serialized bits are 1,1,0,0,0,1,0,1 (0xA3 LSB first).
  - Only one `tx_done_tick`.
- Back-to-back frames: hold `tx_start` = 1 with `din` = 8'h00, 8'hFF.
  - Required: two complete frames, separated by exactly one clk of `tx` = 1 after the first `tx_done_tick`.
- Async reset mid-frame: drop `reset` during DATA bit 3, off a clk edge.
  - Required: `tx` = 1 and `tx_busy` = 0 within the same timestep, with no `tx_done_tick`.
  - After release, a new 8'h0F frame transmits correctly.
- Real baud: use uart_baud_rate_gen's `tick` with `din` = 8'h41.
  - Required: each bit measures 8680 ns ±2% on `tx`.
